// File: rtl/rr_mux_arbiter_if.sv
// Bus bundle for rr_mux_arbiter: four requesters sharing one 4:1 single-bit channel.
//   master : the data sources (drive req/d, observe grant, select and channel)
//   slave  : the arbiter (samples req/d, drives gnt, s1/s0, busy, y)
interface rr_mux_arbiter_if;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       busy;
  logic       y;

  modport master (output req, d, input gnt, s1, s0, busy, y);
  modport slave  (input req, d, output gnt, s1, s0, busy, y);
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that owns the select of a shared 4:1 single-bit mux channel.
// Grants one source at a time and always inserts a one-cycle break-before-make gap.
// Optional hold-time limit compiled in with `define RR_MUX_ARB_HOLD_LIMIT_EN.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    rr_mux_arbiter_if.slave: req/d in; gnt, s1/s0, busy (registered), y (comb) out
// Parameter:
//   MAX_HOLD  cycles a grant may be held when the hold limit is compiled in (1..255)
module rr_mux_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_mux_arbiter_if.slave    bus
);

  localparam int unsigned N_SRC = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 8;

`ifdef RR_MUX_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic               win_vld_c;
  logic [IDX_W-1:0]   win_idx_c;
  logic               hold_hit_c;

  // Round-robin pick: scan offsets 4..1 so the lowest offset from last is assigned last and wins.
  always_comb begin : rr_pick
    logic [IDX_W-1:0] cand;
    win_vld_c = 1'b0;
    win_idx_c = last_q;
    cand      = last_q;
    for (int i = N_SRC; i >= 1; i--) begin
      cand = last_q + IDX_W'(i);
      if (bus.req[cand]) begin
        win_vld_c = 1'b1;
        win_idx_c = cand;
      end
    end
  end

  // Forced release fires on the cycle the owner has held for MAX_HOLD-1 counted cycles.
  assign hold_hit_c = HOLD_EN && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

  // Next-state and registered-output logic.
  always_comb begin : next_state
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    last_d     = last_q;
    busy_d     = busy_q;
    hold_cnt_d = hold_cnt_q;

    case (state_q)
      IDLE, GAP: begin
        if (win_vld_c) begin
          state_d    = GRANT;
          gnt_d      = N_SRC'(1) << win_idx_c;
          sel_d      = win_idx_c;
          last_d     = win_idx_c;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      GRANT: begin
        hold_cnt_d = (hold_cnt_q == {CNT_W{1'b1}}) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
        // Select is kept through the gap so the channel index stays stable.
        if (!bus.req[sel_q] || hold_hit_c) begin
          state_d = GAP;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; last resets to 3 so source 0 is searched first.
  always_ff @(posedge clk) begin : regs
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      last_q     <= IDX_W'(3);
      busy_q     <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.s1   = sel_q[1];
  assign bus.s0   = sel_q[0];
  assign bus.busy = busy_q;
  assign bus.y    = busy_q & bus.d[sel_q];

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural owner/last/held model.
module tb_rr_mux_arbiter;

  localparam int unsigned MAX_HOLD = 4;

`ifdef RR_MUX_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_LIMIT = 1'b1;
`else
  localparam bit HOLD_LIMIT = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d;

  int tests;
  int fails;

  // Reference model: owner index (-1 = none), last winner, selected index, cycles held.
  int m_owner;
  int m_last;
  int m_sel;
  int m_held;

  rr_mux_arbiter_if bus ();
  assign bus.req = req;
  assign bus.d   = d;

  rr_mux_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge and apply the arbitration rules to the model with the sampled inputs.
  task automatic tick();
    bit found;
    @(posedge clk);
    if (!rst_n) begin
      m_owner = -1;
      m_last  = 3;
      m_sel   = 0;
      m_held  = 0;
    end else if (m_owner >= 0) begin
      m_held = m_held + 1;
      if (!req[m_owner] || (HOLD_LIMIT && m_held >= int'(MAX_HOLD)))
        m_owner = -1;
    end else begin
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
        int c;
        c = (m_last + i) % 4;
        if (!found && req[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_last  = c;
          m_sel   = c;
          m_held  = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    d     = 4'b1111;
    tick();
    tick();
    tests++;
    if (bus.gnt !== 4'b0000 || {bus.s1, bus.s0} !== 2'b00 || bus.busy !== 1'b0 || bus.y !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: gnt=%b sel=%b busy=%b y=%b, required gnt=0000 sel=00 busy=0 y=0",
               bus.gnt, {bus.s1, bus.s0}, bus.busy, bus.y);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (bus.gnt !== 4'b0001 || bus.y !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_grant: gnt=%b y=%b, required gnt=0001 y=1", bus.gnt, bus.y);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_single();
    req = 4'b0100;
    d   = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++;
      if (bus.gnt !== 4'b0100 || {bus.s1, bus.s0} !== 2'b10 || bus.y !== 1'b1) begin
        fails++;
        $display("FAIL single_grant cyc %0d: gnt=%b sel=%b y=%b, required gnt=0100 sel=10 y=1",
                 c, bus.gnt, {bus.s1, bus.s0}, bus.y);
      end
    end
    req = 4'b0000;
    tick();
    tests++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.y !== 1'b0) begin
      fails++;
      $display("FAIL single_release: gnt=%b busy=%b y=%b, required gnt=0000 busy=0 y=0",
               bus.gnt, bus.busy, bus.y);
    end
    tick();
  endtask

  task automatic reset_one();
    req   = 4'b0000;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

`ifdef RR_MUX_ARB_HOLD_LIMIT_EN
  task automatic test_hold_limit();
    logic [3:0] exp_g;
    reset_one();
    req = 4'b1111;
    d   = 4'b0000;
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'(1) << (g % 4);
      for (int c = 0; c < int'(MAX_HOLD); c++) begin
        tick();
        tests++;
        if (bus.gnt !== exp_g || bus.busy !== 1'b1) begin
          fails++;
          $display("FAIL hold_grant g%0d c%0d: gnt=%b busy=%b, required gnt=%b busy=1",
                   g, c, bus.gnt, bus.busy, exp_g);
        end
      end
      tick();
      tests++;
      if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
        fails++;
        $display("FAIL hold_gap g%0d: gnt=%b busy=%b, required gnt=0000 busy=0", g, bus.gnt, bus.busy);
      end
    end
    req = 4'b0000;
    tick();
  endtask
`else
  task automatic test_no_limit();
    int bad;
    reset_one();
    req = 4'b0011;
    d   = 4'b0000;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.gnt !== 4'b0001) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL no_limit_hold: %0d of 20 cycles without gnt=0001 (last gnt=%b)", bad, bus.gnt);
    end
    req = 4'b0010;
    tick();
    tests++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL no_limit_gap: gnt=%b busy=%b, required gnt=0000 busy=0", bus.gnt, bus.busy);
    end
    tick();
    tests++;
    if (bus.gnt !== 4'b0010 || {bus.s1, bus.s0} !== 2'b01) begin
      fails++;
      $display("FAIL no_limit_handoff: gnt=%b sel=%b, required gnt=0010 sel=01", bus.gnt, {bus.s1, bus.s0});
    end
    req = 4'b0000;
    tick();
  endtask
`endif

  task automatic test_rotation();
    reset_one();
    req = 4'b1000;
    tick();
    tests++;
    if (bus.gnt !== 4'b1000) begin
      fails++;
      $display("FAIL rotation_setup: gnt=%b, required 1000", bus.gnt);
    end
    req = 4'b0011;
    tick();
    tests++;
    if (bus.gnt !== 4'b0000 || {bus.s1, bus.s0} !== 2'b11) begin
      fails++;
      $display("FAIL rotation_gap: gnt=%b sel=%b, required gnt=0000 sel=11", bus.gnt, {bus.s1, bus.s0});
    end
    tick();
    tests++;
    if (bus.gnt !== 4'b0001 || {bus.s1, bus.s0} !== 2'b00) begin
      fails++;
      $display("FAIL rotation_next: gnt=%b sel=%b, required gnt=0001 sel=00", bus.gnt, {bus.s1, bus.s0});
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    reset_one();
    req = 4'b0100;
    d   = 4'b1111;
    tick();
    tests++;
    if (bus.gnt !== 4'b0100) begin
      fails++;
      $display("FAIL midrst_setup: gnt=%b, required 0100", bus.gnt);
    end
    rst_n = 1'b0;
    tick();
    tests++;
    if (bus.gnt !== 4'b0000 || {bus.s1, bus.s0} !== 2'b00 || bus.busy !== 1'b0 || bus.y !== 1'b0) begin
      fails++;
      $display("FAIL midrst_zero: gnt=%b sel=%b busy=%b y=%b, required all zero",
               bus.gnt, {bus.s1, bus.s0}, bus.busy, bus.y);
    end
    rst_n = 1'b1;
    req   = 4'b0110;
    tick();
    tests++;
    if (bus.gnt !== 4'b0010) begin
      fails++;
      $display("FAIL midrst_regrant: gnt=%b, required 0010", bus.gnt);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] exp_g;
    logic [1:0] exp_s;
    logic       exp_b;
    logic       exp_y;
    reset_one();
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(3) == 0) req[b] = ~req[b];
      d     = 4'($urandom_range(15));
      rst_n = ($urandom_range(79) == 0) ? 1'b0 : 1'b1;
      tick();
      exp_b = (m_owner >= 0);
      exp_g = exp_b ? (4'(1) << m_owner) : 4'b0000;
      exp_s = 2'(m_sel);
      exp_y = exp_b ? d[m_sel] : 1'b0;
      tests++;
      if (bus.gnt !== exp_g || {bus.s1, bus.s0} !== exp_s || bus.busy !== exp_b || bus.y !== exp_y) begin
        fails++;
        $display("FAIL random cyc %0d: gnt=%b sel=%b busy=%b y=%b, required gnt=%b sel=%b busy=%b y=%b",
                 n, bus.gnt, {bus.s1, bus.s0}, bus.busy, bus.y, exp_g, exp_s, exp_b, exp_y);
      end
    end
    rst_n = 1'b1;
    req   = 4'b0000;
    tick();
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    req     = 4'b0000;
    d       = 4'b0000;
    m_owner = -1;
    m_last  = 3;
    m_sel   = 0;
    m_held  = 0;
    test_reset();
    test_single();
`ifdef RR_MUX_ARB_HOLD_LIMIT_EN
    test_hold_limit();
`else
    test_no_limit();
`endif
    test_rotation();
    test_reset_mid_grant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares one 4:1 single-bit mux channel among four requesters. It owns the mux select lines (`s1`, `s0`) and drives the selected data bit out. It grants one requester at a time, optionally limits hold time, and inserts a break-before-make gap between owners. It sits between the four data sources and the shared `FourToOne_mux`-style channel, and replaces ad-hoc select driving.

## Interface
- `MAX_HOLD`, default 8: maximum cycles one grant may be held when the hold limit is compiled in; legal range 1..255.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  synchronous active-low reset.
- `req`  input  4  request per source; bit i = source i; level-held while the source wants the channel.
- `d`  input  4  data bit per source; `d[i]` belongs to source i.
- `gnt`  output  4  one-hot registered grant; all zero when no owner.
- `s1`, `s0`  output  1 each  registered mux select; `{s1,s0}` = index of current or last owner.
- `busy`  output  1  registered; high while any grant is active.
- `y`  output  1  shared channel output: `d[{s1,s0}]` when `busy`, else 0. Combinational from `d` and registered select.

## Operation
- States:
  - `IDLE`: no owner, arbitrate.
  - `GRANT`: owner holds the channel.
  - `GAP`: one-cycle dead time, arbitrate.
- Arbitration, evaluated in `IDLE` and `GAP` on sampled `req`:
  - Search order is `last+1, last+2, last+3, last` (mod 4).
  - The first asserted bit wins and is loaded into `gnt`, `{s1,s0}` and `last`. Next state is `GRANT`.
  - No request: stay in `IDLE` (from `GAP`, go to `IDLE`).
- `GRANT` exit, evaluated every cycle, next state `GAP`, `gnt` cleared:
  - `req[owner]` sampled low, or
  - hold limit reached (see Configuration).
- `GAP` always lasts exactly one cycle, with `gnt` = 0 and `busy` = 0. `{s1,s0}` keeps the last owner.
- `hold_cnt` (8 bits):
  - Cleared on grant load.
  - Increments each cycle in `GRANT`, saturating at 255.
- Requests from non-owners never pre-empt the owner.
- `req` for the owner may be dropped and reasserted. Once dropped, the source re-arbitrates.
- At most one `gnt` bit is ever set. `gnt`, `busy` and `{s1,s0}` all change on the same edge.
- Reset values, applied when `rst_n` is low at a rising edge, from any state:
  - state = `IDLE`
  - `gnt` = 0000, `s1` = 0, `s0` = 0, `busy` = 0, `y` = 0
  - `hold_cnt` = 0
  - `last` = 3, so source 0 has top priority after reset.

## Timing
- Grant latency: `req` high at edge k (channel idle) gives `gnt`/`busy` high after edge k. That is 1 cycle.
- Release on request drop:
  - `req[owner]` low at edge k: `gnt` low after edge k (`GAP`).
  - The next owner's `gnt` is high after edge k+1.
- Forced release: a grant loaded at edge k is cleared at edge k+`MAX_HOLD`, so the owner holds for exactly `MAX_HOLD` cycles.
- Simultaneous owner drop and new requests: always one `GAP` cycle, then round-robin from the dropping owner.
- Reset mid-`GRANT` or mid-`GAP`: outputs return to reset values after that edge. No residual gap is inserted.
- `y` follows `d` combinationally within the cycle; there is no registered data path.

## Configuration
- `RR_MUX_ARB_HOLD_LIMIT_EN` defined:
  - In `GRANT`, when `hold_cnt == MAX_HOLD-1` and `req[owner]` is still high, the next state is `GAP`.
  - The owner loses priority via `last`.
- `RR_MUX_ARB_HOLD_LIMIT_EN` undefined:
  - The grant is held until `req[owner]` drops, with no timeout.
  - `hold_cnt` and `MAX_HOLD` have no effect on outputs.

## Test plan
- **Reset:** `rst_n` = 0 for 2 edges with `req` = 1111, `d` = 1111 -> `gnt` = 0000, `{s1,s0}` = 00, `busy` = 0, `y` = 0. On the first edge after release -> `gnt` = 0001, `y` = 1.
- **Single requester:** `req` = 0100 for 3 cycles, `d` = 0100 -> `gnt` = 0100 after 1 edge, `{s1,s0}` = 10, `y` = 1 for 3 cycles. `req` = 0000 -> `gnt` = 0000, `busy` = 0 next edge, `y` = 0.
- **Hold limit (macro defined, `MAX_HOLD` = 4):** `req` = 1111 held constantly -> grants 0001, 0010, 0100, 1000, 0001. Each lasts 4 cycles, separated by single `GAP` cycles.
- **No limit (macro undefined):** `req` = 0011 held for 20 cycles -> `gnt` = 0001 for all 20 cycles. Drop `req[0]` -> `GAP`, then `gnt` = 0010, `{s1,s0}` = 01.
- **Handoff with rotation:** owner 3 drops while `req` = 0011 -> one `GAP` cycle, then `gnt` = 0001 (search order from 3 is 0,1,2,3).
- **Reset mid-grant:** `rst_n` = 0 for 1 edge while `gnt` = 0100 -> all outputs zero next edge. With `req` = 0110 after release -> `gnt` = 0010 (`last` reset to 3).
